// File: rtl/nested_loop_sched.sv
// nested_loop_sched: sequencer for the two-level nested-loop action datapath.
// For each outer iteration it issues one act_outer strobe and then inner_n
// act_inner strobes, with the loop indices on x_idx / y_idx. A one-cycle done
// pulse follows the last action.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               run request, sampled only while idle
//   outer_n, inner_n    loop counts, latched when start is accepted
//   hold                stall while sequencing (no strobe, nothing advances)
//   busy                run in progress
//   done                one-cycle completion pulse
//   act_outer/act_inner one-cycle action strobes (never high together)
//   x_idx, y_idx        indices belonging to the current strobe
//
// Optional feature (macro NLS_ABORT_EN): adds input abort and output aborted.
// abort while sequencing ends the run early; aborted pulses together with done.
// All outputs are registered.

module nested_loop_sched #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] outer_n,
  input  logic [CNT_W-1:0] inner_n,
  input  logic             hold,
`ifdef NLS_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic             busy,
  output logic             done,
  output logic             act_outer,
  output logic             act_inner,
  output logic [CNT_W-1:0] x_idx,
  output logic [CNT_W-1:0] y_idx
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  typedef enum logic [1:0] {StIdle, StOuter, StInner, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] y_q, y_d;
  logic [CNT_W-1:0] on_q, on_d;   // latched outer count
  logic [CNT_W-1:0] in_q, in_d;   // latched inner count
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             act_outer_q, act_outer_d;
  logic             act_inner_q, act_inner_d;
  logic [CNT_W-1:0] x_idx_q, x_idx_d;
  logic [CNT_W-1:0] y_idx_q, y_idx_d;
`ifdef NLS_ABORT_EN
  // Remembers that DONE was reached by abort so aborted can pulse with done.
  logic             ab_pend_q, ab_pend_d;
  logic             aborted_q, aborted_d;
`endif

  logic last_x;
  logic last_y;

  // Compare against latched counts only; the input counts may change mid-run.
  assign last_x = (x_q == on_q - CntOne);
  assign last_y = (y_q == in_q - CntOne);

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    on_d        = on_q;
    in_d        = in_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    act_outer_d = 1'b0;
    act_inner_d = 1'b0;
    x_idx_d     = x_idx_q;
    y_idx_d     = y_idx_q;
`ifdef NLS_ABORT_EN
    ab_pend_d   = ab_pend_q;
    aborted_d   = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          on_d    = outer_n;
          in_d    = inner_n;
          x_d     = '0;
          y_d     = '0;
          busy_d  = 1'b1;
          state_d = (outer_n != '0) ? StOuter : StDone;
        end
      end

      StOuter: begin
`ifdef NLS_ABORT_EN
        if (abort) begin
          ab_pend_d = 1'b1;
          state_d   = StDone;
        end else
`endif
        if (!hold) begin
          act_outer_d = 1'b1;
          x_idx_d     = x_q;
          y_idx_d     = '0;
          if (in_q != '0) begin
            state_d = StInner;
          end else if (last_x) begin
            state_d = StDone;
          end else begin
            x_d = x_q + CntOne;
          end
        end
      end

      StInner: begin
`ifdef NLS_ABORT_EN
        if (abort) begin
          ab_pend_d = 1'b1;
          state_d   = StDone;
        end else
`endif
        if (!hold) begin
          act_inner_d = 1'b1;
          x_idx_d     = x_q;
          y_idx_d     = y_q;
          if (last_y) begin
            y_d = '0;
            if (last_x) begin
              state_d = StDone;
            end else begin
              x_d     = x_q + CntOne;
              state_d = StOuter;
            end
          end else begin
            y_d = y_q + CntOne;
          end
        end
      end

      StDone: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
`ifdef NLS_ABORT_EN
        aborted_d = ab_pend_q;
        ab_pend_d = 1'b0;
`endif
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      x_q         <= '0;
      y_q         <= '0;
      on_q        <= '0;
      in_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      act_outer_q <= 1'b0;
      act_inner_q <= 1'b0;
      x_idx_q     <= '0;
      y_idx_q     <= '0;
`ifdef NLS_ABORT_EN
      ab_pend_q   <= 1'b0;
      aborted_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      on_q        <= on_d;
      in_q        <= in_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      act_outer_q <= act_outer_d;
      act_inner_q <= act_inner_d;
      x_idx_q     <= x_idx_d;
      y_idx_q     <= y_idx_d;
`ifdef NLS_ABORT_EN
      ab_pend_q   <= ab_pend_d;
      aborted_q   <= aborted_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign act_outer = act_outer_q;
  assign act_inner = act_inner_q;
  assign x_idx     = x_idx_q;
  assign y_idx     = y_idx_q;
`ifdef NLS_ABORT_EN
  assign aborted   = aborted_q;
`endif

endmodule
